// File: rtl/matrix_loader.sv
// matrix_loader: byte-serial assembler for one scalar-multiply operand frame.
// Accepts a scalar byte followed by N_ELEMS matrix bytes, then holds the
// completed frame on registered outputs until the consumer acknowledges it.
module matrix_loader #(
  parameter int ELEM_W  = 8,
  parameter int N_ELEMS = 25
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ELEM_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        clear,
  output logic [ELEM_W-1:0]           data_out,
  output logic [N_ELEMS*ELEM_W-1:0]   matrix_out,
  output logic                        frame_valid,
  input  logic                        frame_ack,
  output logic [4:0]                  elem_count
);

  typedef enum logic [1:0] {
    S_SCALAR = 2'd0,
    S_ELEM   = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t state;

  // in_ready is a register, so it never depends combinationally on in_valid
  logic accept;
  assign accept = in_valid && in_ready;

  // Frame FSM: all outputs registered; clear overrides byte acceptance and ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SCALAR;
      in_ready    <= 1'b1;
      elem_count  <= 5'd0;
      data_out    <= '0;
      matrix_out  <= '0;
      frame_valid <= 1'b0;
    end else if (clear) begin
      // Abort drops the partial frame but leaves data registers untouched
      state       <= S_SCALAR;
      in_ready    <= 1'b1;
      elem_count  <= 5'd0;
      frame_valid <= 1'b0;
    end else begin
      case (state)
        S_SCALAR: begin
          if (accept) begin
            data_out <= in_data;
            state    <= S_ELEM;
          end
        end
        S_ELEM: begin
          if (accept) begin
            // Slot index equals the number of elements already loaded
            for (int i = 0; i < N_ELEMS; i++) begin
              if (elem_count == 5'(i)) matrix_out[i*ELEM_W +: ELEM_W] <= in_data;
            end
            elem_count <= elem_count + 5'd1;
            if (elem_count == 5'(N_ELEMS-1)) begin
              state       <= S_FULL;
              in_ready    <= 1'b0;
              frame_valid <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (frame_ack) begin
            state       <= S_SCALAR;
            in_ready    <= 1'b1;
            elem_count  <= 5'd0;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_SCALAR;
          in_ready    <= 1'b1;
          elem_count  <= 5'd0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: one task per scenario, inline checks.
module tb_matrix_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         clear;
  logic [7:0]   data_out;
  logic [199:0] matrix_out;
  logic         frame_valid;
  logic         frame_ack;
  logic [4:0]   elem_count;

  int total = 0;
  int bad   = 0;

  matrix_loader #(.ELEM_W(8), .N_ELEMS(25)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .data_out(data_out),
    .matrix_out(matrix_out), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  // Drive one byte for one clock; caller guarantees in_ready is high
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0; frame_ack = 1'b0;
    #12;
    total++;
    if (data_out !== 8'h00 || matrix_out !== '0 || frame_valid !== 1'b0 || elem_count !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: data=%h fv=%b cnt=%0d mat_nonzero=%b, want 0", data_out, frame_valid, elem_count, |matrix_out);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_frame();
    int ready_bad = 0;
    for (int i = 0; i < 26; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'h03 : 8'(i);
      if (in_ready !== 1'b1) ready_bad++;
      if (i == 25 && frame_valid !== 1'b0) ready_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (ready_bad != 0) begin bad++; $display("FAIL full_ready_window: %0d bad cycles, want 0", ready_bad); end
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL full_fv: got %b want 1", frame_valid); end
    total++;
    if (data_out !== 8'h03) begin bad++; $display("FAIL full_scalar: got %h want 03", data_out); end
    total++;
    if (matrix_out[7:0] !== 8'h01 || matrix_out[199:192] !== 8'h19) begin
      bad++; $display("FAIL full_ends: got %h/%h want 01/19", matrix_out[7:0], matrix_out[199:192]);
    end
    total++;
    if (elem_count !== 5'd25 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_cnt_ready: cnt=%0d rdy=%b want 25/0", elem_count, in_ready);
    end
  endtask

  task automatic test_stall();
    logic [199:0] snap;
    int changed = 0;
    snap = matrix_out;
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (matrix_out !== snap || data_out !== 8'h03 || frame_valid !== 1'b1 ||
          elem_count !== 5'd25 || in_ready !== 1'b0) changed++;
    end
    total++;
    if (changed != 0) begin bad++; $display("FAIL stall_frozen: %0d cycles changed, want 0", changed); end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    total++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1 || elem_count !== 5'd0) begin
      bad++; $display("FAIL ack_release: fv=%b rdy=%b cnt=%0d want 0/1/0", frame_valid, in_ready, elem_count);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (data_out !== 8'hFF || elem_count !== 5'd0) begin
      bad++; $display("FAIL post_ack_scalar: data=%h cnt=%0d want ff/0", data_out, elem_count);
    end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_clear();
    send(8'h40);
    for (int i = 0; i < 10; i++) send(8'h41 + 8'(i));
    total++;
    if (elem_count !== 5'd10) begin bad++; $display("FAIL clear_pre_cnt: got %0d want 10", elem_count); end
    in_valid = 1'b1; in_data = 8'hAA; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    total++;
    if (elem_count !== 5'd0 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clear_state: cnt=%0d fv=%b rdy=%b want 0/0/1", elem_count, frame_valid, in_ready);
    end
    total++;
    // slot 10 still holds 0x0B from the first frame; scalar still 0x40
    if (data_out !== 8'h40 || matrix_out[87:80] !== 8'h0B || matrix_out[79:72] !== 8'h4A) begin
      bad++; $display("FAIL clear_no_write: data=%h s10=%h s9=%h want 40/0b/4a", data_out, matrix_out[87:80], matrix_out[79:72]);
    end
    send(8'h77);
    total++;
    if (data_out !== 8'h77 || elem_count !== 5'd0) begin
      bad++; $display("FAIL clear_next_scalar: data=%h cnt=%0d want 77/0", data_out, elem_count);
    end
    send(8'h78);
    total++;
    if (matrix_out[7:0] !== 8'h78 || elem_count !== 5'd1) begin
      bad++; $display("FAIL clear_next_elem: s0=%h cnt=%0d want 78/1", matrix_out[7:0], elem_count);
    end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // Random gaps with frame_ack pulsed on idle cycles while the frame is incomplete
  task automatic test_gaps();
    logic [199:0] exp_mat;
    int idx = 0;
    int cyc = 0;
    int errs = 0;
    logic v;
    for (int i = 0; i < 25; i++) exp_mat[i*8 +: 8] = 8'h11 + 8'(i);
    while (idx < 26 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      in_valid  = v;
      in_data   = 8'h10 + 8'(idx);
      frame_ack = ~v;
      if (in_ready !== 1'b1) errs++;
      tick();
      cyc++;
      if (v) idx++;
      if (idx < 26 && frame_valid !== 1'b0) errs++;
      if (idx >= 1 && elem_count !== 5'(idx - 1)) errs++;
    end
    in_valid = 1'b0; frame_ack = 1'b0;
    total++;
    if (idx != 26 || errs != 0) begin bad++; $display("FAIL gaps_progress: accepted=%0d errs=%0d want 26/0", idx, errs); end
    total++;
    if (frame_valid !== 1'b1 || elem_count !== 5'd25) begin
      bad++; $display("FAIL gaps_done: fv=%b cnt=%0d want 1/25", frame_valid, elem_count);
    end
    total++;
    if (matrix_out !== exp_mat || data_out !== 8'h10) begin
      bad++; $display("FAIL gaps_data: mat=%h data=%h want %h/10", matrix_out, data_out, exp_mat);
    end
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [199:0] exp_mat;
    send(8'h55);
    for (int i = 0; i < 12; i++) send(8'h60 + 8'(i));
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (data_out !== 8'h00 || matrix_out !== '0 || elem_count !== 5'd0 || frame_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: data=%h cnt=%0d fv=%b mat_nonzero=%b want all 0", data_out, elem_count, frame_valid, |matrix_out);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    send(8'hA0);
    for (int i = 0; i < 25; i++) begin
      send(8'hB0 + 8'(i));
      exp_mat[i*8 +: 8] = 8'hB0 + 8'(i);
    end
    total++;
    if (frame_valid !== 1'b1 || data_out !== 8'hA0 || matrix_out !== exp_mat) begin
      bad++; $display("FAIL post_reset_frame: fv=%b data=%h mat=%h want 1/a0/%h", frame_valid, data_out, matrix_out, exp_mat);
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] exp_mat;
    for (int i = 0; i < 25; i++) exp_mat[i*8 +: 8] = 8'hB0 + 8'(i);
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    send(8'h05);
    for (int i = 0; i < 24; i++) send(8'hB0 + 8'(i));
    total++;
    if (frame_valid !== 1'b0 || elem_count !== 5'd24) begin
      bad++; $display("FAIL b2b_partial: fv=%b cnt=%0d want 0/24", frame_valid, elem_count);
    end
    send(8'hC8);
    total++;
    if (frame_valid !== 1'b1 || data_out !== 8'h05 || matrix_out !== exp_mat) begin
      bad++; $display("FAIL b2b_frame: fv=%b data=%h mat=%h want 1/05/%h", frame_valid, data_out, matrix_out, exp_mat);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_clear();
    test_gaps();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Byte-serial input stage that assembles one operand frame for the scalar-multiply datapath: an 8-bit scalar followed by 25 elements of a 5x5 matrix, each 8 bits.
- Drives the multiplier's scalar input (data) and its packed 200-bit matrix input (matrix_a) from registers.
- Holds a completed frame stable until the downstream stage acknowledges it.
- Decouples the byte-wide host interface from the wide combinational datapath.

Parameters:
- ELEM_W, 8, width of the scalar and of each matrix element in bits.
- N_ELEMS, 25, matrix elements per frame (5x5).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  ELEM_W  byte from the host.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- clear  input  1  synchronous abort of the current frame.
- data_out  output  ELEM_W  registered scalar; feeds the multiplier's data input.
- matrix_out  output  N_ELEMS*ELEM_W  registered packed matrix; element i at bits [i*ELEM_W +: ELEM_W].
- frame_valid  output  1  complete frame present on data_out/matrix_out.
- frame_ack  input  1  downstream has consumed the frame.
- elem_count  output  5  number of matrix elements loaded in the current frame (0..25).

Behaviour:
- Handshake: a byte is accepted on any rising edge where in_valid && in_ready. No combinational path from in_valid to in_ready.
- Reset (rst_n=0, asynchronous):
  - state=S_SCALAR, elem_count=0, data_out=0, matrix_out=0, frame_valid=0.
  - in_ready=1 once rst_n deasserts.
- States:
  - S_SCALAR: in_ready=1. An accepted byte is written to data_out, elem_count stays 0, next state is S_ELEM.
  - S_ELEM: in_ready=1. An accepted byte is written to matrix_out slot elem_count, then elem_count increments. When the accepted byte is slot N_ELEMS-1, next state is S_FULL.
  - S_FULL: in_ready=0, frame_valid=1, elem_count=25. On frame_ack, next state is S_SCALAR and elem_count returns to 0.
- Timing:
  - frame_valid rises on the edge that accepts element 24, so it is visible the cycle after the last byte.
  - frame_valid falls on the edge that samples frame_ack=1. in_ready is high in the cycle after the ack.
  - Back-to-back frames: one idle cycle of in_ready=0 minimum per frame (the S_FULL cycle). Peak throughput is 26 bytes per 27 cycles.
- Data stability:
  - data_out and matrix_out change only on accepted bytes. Stale elements from the previous frame remain until overwritten.
  - Downstream must qualify with frame_valid.
  - While frame_valid=1, all outputs are frozen.
- frame_ack with frame_valid=0: ignored.
- clear:
  - In any state, clear=1 forces next state S_SCALAR, elem_count=0, frame_valid=0.
  - data_out and matrix_out are not zeroed.
  - clear has priority over a simultaneous byte acceptance (the byte is dropped, even though in_ready was 1) and over frame_ack.
- Asynchronous reset mid-frame: partial frame discarded, all registers cleared immediately, regardless of clk.
- Arithmetic: elem_count is a 5-bit unsigned counter, never exceeds 25, no wrap. Slot index equals elem_count.
- in_valid held high with constant data across a stall: no duplicate acceptance, because in_ready=0 in S_FULL.

Test Plan:
- Reset, then stream 0x03 followed by 1..25 with in_valid constant high → in_ready high for 26 cycles, then frame_valid=1 one cycle after byte 25. data_out=0x03, matrix_out[7:0]=0x01, matrix_out[199:192]=0x19, elem_count=25, in_ready=0.
- Full frame loaded, frame_ack held low for 10 cycles while in_valid=1 with 0xFF → outputs unchanged, no byte accepted. Assert frame_ack → frame_valid=0 and in_ready=1 next cycle. The next 0xFF is accepted as the scalar.
- Load scalar plus 10 elements, pulse clear in the same cycle as an in_valid byte 0xAA → elem_count=0, state S_SCALAR, 0xAA not written anywhere. The next byte lands in data_out.
- Random in_valid gaps (about 50% duty) over a frame of 0x10..0x29 → identical packed matrix_out to the gap-free case, frame_valid after exactly 26 accepted bytes.
- Deassert rst_n asynchronously (between clock edges) mid-frame after 12 elements → all outputs 0 immediately. After release, a fresh 26-byte frame loads correctly.
- frame_ack pulsed while frame_valid=0 during loading → no effect on elem_count or state.
- Load one frame, then a second frame with only the scalar changed to 0x05 → matrix_out unchanged, data_out=0x05, frame_valid asserts again.
